// File: rtl/disp_pkg.sv
// disp_pkg: shared FSM encoding and BCD adjust constants for the display path
package disp_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_ADJ_THRESH = 5;
  localparam int BCD_ADJ_ADD = 3;
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: per-digit shift-add-3 adjust
module bcd_add3
  import disp_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d,
  output logic [BCD_DIGIT_W-1:0] q
);
  assign q = d >= BCD_DIGIT_W'(BCD_ADJ_THRESH) ? d + BCD_DIGIT_W'(BCD_ADJ_ADD) : d;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 binary to BCD converter, one bit per clock
// Define LEADING_ZERO_BLANK_EN to drive the leading-zero blank mask; otherwise blank stays zero.
module bin2bcd_seq
  import disp_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [WIDTH-1:0]              bin,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic [DIGITS-1:0]             blank
);
  localparam int BW = BCD_DIGIT_W * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);
`else
  localparam logic [DIGITS-1:0] BLANK_RST = '0;
`endif
  if (64'd10 ** DIGITS <= (64'd1 << WIDTH) - 64'd1) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS too small to hold 2**WIDTH-1");
  end
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    work_bcd, adj_bcd, nxt_bcd;
  logic [WIDTH-1:0] work_bin, nxt_bin;
  logic [DIGITS-1:0] nxt_blank;
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_add3 u_add3 (
      .d(work_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .q(adj_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end
  assign {nxt_bcd, nxt_bin} = {adj_bcd, work_bin} << 1;
`ifdef LEADING_ZERO_BLANK_EN
  // running AND of "this and every higher digit is zero"; units digit never blanks
  always_comb begin
    logic z;
    z = 1'b1;
    nxt_blank = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      z = z && (nxt_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
      nxt_blank[i] = z;
    end
  end
`else
  assign nxt_blank = '0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      work_bcd <= '0;
      work_bin <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      blank    <= BLANK_RST;
    end else begin
      case (state)
        IDLE: if (start) begin
          work_bcd <= '0;
          work_bin <= bin;
          cnt      <= '0;
          busy     <= 1'b1;
          state    <= SHIFT;
        end
        SHIFT: begin
          work_bcd <= nxt_bcd;
          work_bin <= nxt_bin;
          cnt      <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            bcd   <= nxt_bcd;
            blank <= nxt_blank;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
